// File: rtl/vaddr_gen.sv
`default_nettype none
//==============================================================================
// Module   : vaddr_gen
// Purpose  : Vector address generator. Accepts one vector access request
//            (base, signed element stride, element count) and issues the
//            per-element addresses as registered beats of PORTS addresses,
//            with per-lane valid masks and a valid/ready output handshake.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid/ready   - request handshake
//            req_base          - address of element 0
//            req_stride        - signed element stride (address units)
//            req_count         - element count, clamped to LANES
//            out_valid/ready   - beat handshake towards the memory banks
//            out_addr          - PORTS lane addresses
//            out_mask          - per-lane valid bits
//            out_first         - beat carries element 0
//            out_last          - final beat of the request
//            busy              - request in progress
// Revision : 1.0 - initial release
//==============================================================================
module vaddr_gen #(
    parameter int ADDR_W   = 16,
    parameter int LANES    = 16,
    parameter int PORTS    = 4,
    parameter int STRIDE_W = 8,
    parameter int CNT_W    = $clog2(LANES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_base,
    input  logic [STRIDE_W-1:0] req_stride,
    input  logic [CNT_W-1:0]    req_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDR_W-1:0]   out_addr [PORTS-1:0],
    output logic [PORTS-1:0]    out_mask,
    output logic                out_first,
    output logic                out_last,
    output logic                busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_step      = ADDR_W'(PORTS);
    localparam logic [CNT_W-1:0]  c_ports_cnt = CNT_W'(PORTS);
    localparam logic [CNT_W-1:0]  c_lanes_cnt = CNT_W'(LANES);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_stride;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_elem_idx;
    logic                r_req_ready;
    logic                r_out_valid;
    logic                r_busy;

    logic [CNT_W-1:0]    w_count_clamped;
    logic [ADDR_W-1:0]   w_stride_sext;
    logic                w_last_beat;
    logic                w_issue;

    assign w_count_clamped = (req_count > c_lanes_cnt) ? c_lanes_cnt : req_count;
    // Signed cast makes the size cast sign-extend the stride.
    assign w_stride_sext   = ADDR_W'($signed(req_stride));
    assign w_last_beat     = (r_remaining <= c_ports_cnt);
    assign w_issue         = (r_state == S_ISSUE);

    // Lane addresses are derived from registered state only, so there is no
    // combinational path from the request inputs to the beat outputs.
    for (genvar p = 0; p < PORTS; p++) begin : g_lane
        localparam logic [ADDR_W-1:0] c_lane_off = ADDR_W'(p);
        localparam logic [CNT_W-1:0]  c_lane_cnt = CNT_W'(p);
        assign out_addr[p] = r_cur_addr + (c_lane_off * r_stride);
        assign out_mask[p] = w_issue && (c_lane_cnt < r_remaining);
    end

    // first/last are qualified by the state so both read 0 while idle.
    assign out_first = w_issue && (r_elem_idx == '0);
    assign out_last  = w_issue && w_last_beat;

    assign req_ready = r_req_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_elem_idx  <= '0;
            r_req_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_cur_addr  <= req_base;
                        r_stride    <= w_stride_sext;
                        r_remaining <= w_count_clamped;
                        r_elem_idx  <= '0;
                        // A zero-length request is consumed without any beat.
                        if (w_count_clamped != '0) begin
                            r_state     <= S_ISSUE;
                            r_req_ready <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (out_ready) begin
                        r_cur_addr <= r_cur_addr + (c_step * r_stride);
                        r_elem_idx <= r_elem_idx + c_ports_cnt;
                        if (w_last_beat) begin
                            r_remaining <= '0;
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_remaining <= r_remaining - c_ports_cnt;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vaddr_gen.sv
`default_nettype none
//==============================================================================
// Module   : tb_vaddr_gen
// Purpose  : Self-checking bench for vaddr_gen. A beat-list model expands each
//            accepted request into its expected beats; a negedge monitor
//            compares every cycle, and directed sequences pin literal values.
// Revision : 1.0 - initial release
//==============================================================================
module tb_vaddr_gen;

    localparam int ADDR_W   = 16;
    localparam int LANES    = 16;
    localparam int PORTS    = 4;
    localparam int STRIDE_W = 8;
    localparam int CNT_W    = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_base = '0;
    logic [STRIDE_W-1:0] req_stride = '0;
    logic [CNT_W-1:0]    req_count = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [ADDR_W-1:0]   out_addr [PORTS-1:0];
    logic [PORTS-1:0]    out_mask;
    logic                out_first;
    logic                out_last;
    logic                busy;

    vaddr_gen #(
        .ADDR_W  (ADDR_W),
        .LANES   (LANES),
        .PORTS   (PORTS),
        .STRIDE_W(STRIDE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_base  (req_base),
        .req_stride(req_stride),
        .req_count (req_count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_mask  (out_mask),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr [PORTS];
        logic [PORTS-1:0]  mask;
        logic              first;
        logic              last;
    } beat_t;

    beat_t q [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    mon_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats: element i lives at base + i*stride, beat b holds
    // elements b*PORTS .. b*PORTS+PORTS-1, elements beyond the count masked.
    task automatic push_request(input logic [ADDR_W-1:0] base,
                                input logic [STRIDE_W-1:0] stride,
                                input logic [CNT_W-1:0] count);
        int n;
        int nb;
        logic [ADDR_W-1:0] s;
        beat_t bt;
        n  = (int'(count) > LANES) ? LANES : int'(count);
        nb = (n + PORTS - 1) / PORTS;
        s  = {{(ADDR_W-STRIDE_W){stride[STRIDE_W-1]}}, stride};
        for (int b = 0; b < nb; b++) begin
            for (int p = 0; p < PORTS; p++) begin
                logic [ADDR_W-1:0] idx;
                idx        = ADDR_W'(b * PORTS + p);
                bt.addr[p] = base + idx * s;
                bt.mask[p] = ((b * PORTS + p) < n);
            end
            bt.first = (b == 0);
            bt.last  = (b == nb - 1);
            q.push_back(bt);
        end
    endtask

    // Per-cycle compare against the model, then advance the model to what the
    // coming rising edge must do.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() != 0) begin
                check("mon_valid", 32'(out_valid), 32'd1);
                check("mon_ready", 32'(req_ready), 32'd0);
                check("mon_busy",  32'(busy),      32'd1);
                check("mon_mask",  32'(out_mask),  32'(q[0].mask));
                check("mon_first", 32'(out_first), 32'(q[0].first));
                check("mon_last",  32'(out_last),  32'(q[0].last));
                for (int p = 0; p < PORTS; p++)
                    check($sformatf("mon_addr%0d", p), 32'(out_addr[p]), 32'(q[0].addr[p]));
            end else begin
                check("mon_valid", 32'(out_valid), 32'd0);
                check("mon_ready", 32'(req_ready), 32'd1);
                check("mon_busy",  32'(busy),      32'd0);
            end
            if (rst)
                q.delete();
            else if (q.size() != 0) begin
                if (out_ready) void'(q.pop_front());
            end else if (req_valid)
                push_request(req_base, req_stride, req_count);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [ADDR_W-1:0] base,
                           input logic [STRIDE_W-1:0] stride,
                           input logic [CNT_W-1:0] count);
        req_valid  = 1'b1;
        req_base   = base;
        req_stride = stride;
        req_count  = count;
        tick();
        req_valid  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_mask"},  32'(out_mask),  32'd0);
        check({tag, "_first"}, 32'(out_first), 32'd0);
        check({tag, "_last"},  32'(out_last),  32'd0);
        for (int p = 0; p < PORTS; p++)
            check($sformatf("%s_addr%0d", tag, p), 32'(out_addr[p]), 32'd0);
    endtask

    initial begin
        int nbeats;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Unit stride, full vector
        request(16'h0100, 8'd1, 5'd16);
        @(negedge clk);
        check("u_first", 32'(out_first), 32'd1);
        check("u_a0",    32'(out_addr[0]), 32'h0100);
        check("u_a3",    32'(out_addr[3]), 32'h0103);
        check("u_mask",  32'(out_mask), 32'hF);
        tick(); tick(); tick();
        @(negedge clk);
        check("u_last", 32'(out_last), 32'd1);
        check("u_a0_b3", 32'(out_addr[0]), 32'h010C);
        check("u_a3_b3", 32'(out_addr[3]), 32'h010F);
        tick();
        @(negedge clk);
        check("u_ready_after", 32'(req_ready), 32'd1);
        check("u_valid_after", 32'(out_valid), 32'd0);

        // Negative stride with wrap
        request(16'h0002, 8'hFE, 5'd4);
        @(negedge clk);
        check("n_a0", 32'(out_addr[0]), 32'h0002);
        check("n_a1", 32'(out_addr[1]), 32'h0000);
        check("n_a2", 32'(out_addr[2]), 32'hFFFE);
        check("n_a3", 32'(out_addr[3]), 32'hFFFC);
        check("n_fl", 32'({out_first, out_last}), 32'h3);
        check("n_mask", 32'(out_mask), 32'hF);
        tick();

        // Partial vector
        request(16'h2000, 8'd4, 5'd6);
        @(negedge clk);
        check("p_a3_b0", 32'(out_addr[3]), 32'h200C);
        check("p_mask0", 32'(out_mask), 32'hF);
        tick();
        @(negedge clk);
        check("p_a0_b1", 32'(out_addr[0]), 32'h2010);
        check("p_a3_b1", 32'(out_addr[3]), 32'h201C);
        check("p_mask1", 32'(out_mask), 32'h3);
        check("p_last",  32'(out_last), 32'd1);
        tick();

        // Back-pressure on beat 0
        out_ready = 1'b0;
        request(16'h3000, 8'd1, 5'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_a0", 32'(out_addr[0]), 32'h3000);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_a0", 32'(out_addr[0]), 32'h3000);
        tick();
        @(negedge clk);
        check("bp_b1_a0",  32'(out_addr[0]), 32'h3004);
        check("bp_b1_last", 32'(out_last), 32'd1);
        tick();

        // Zero count: consumed, no beat
        request(16'h1234, 8'd1, 5'd0);
        @(negedge clk);
        check("z_valid", 32'(out_valid), 32'd0);
        check("z_ready", 32'(req_ready), 32'd1);
        tick();

        // Count above LANES clamps to 16 -> 4 beats
        request(16'h4000, 8'd2, 5'd31);
        nbeats = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) nbeats++;
            tick();
        end
        check("clamp_beats", 32'(nbeats), 32'd4);

        // Reset during beat 1 of 4
        request(16'h5000, 8'd1, 5'd16);
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("r_b1_a0", 32'(out_addr[0]), 32'h5004);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        request(16'h6000, 8'd3, 5'd4);
        @(negedge clk);
        check("r_new_first", 32'(out_first), 32'd1);
        check("r_new_a0", 32'(out_addr[0]), 32'h6000);
        check("r_new_a1", 32'(out_addr[1]), 32'h6003);
        tick();
        tick();

        check("model_drained", 32'(q.size()), 32'd0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net against a hung simulation.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 100000);
        $fatal(1);
    end

endmodule
`default_nettype wire
